// File: rtl/muldiv_hilo_unit.sv
// HI/LO multiply/divide unit: decodes the HI/LO functs, runs an iterative radix-2
// shift-add multiplier / restoring divider, owns HI/LO and raises stalls on hazards.
module muldiv_hilo_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             op_valid_i,
   input  logic [5:0]       funct_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hilo_rdata_o
);

   localparam logic [5:0] F_MFHI = 6'b010000;
   localparam logic [5:0] F_MTHI = 6'b010001;
   localparam logic [5:0] F_MFLO = 6'b010010;
   localparam logic [5:0] F_MTLO = 6'b010011;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   operand_q, hi_q, lo_q;
   logic               neg_lo_q, neg_rem_q, dz_q, is_div_q;

   logic               is_muldiv, is_hilo_op, accept;
   logic               src1_neg, src2_neg;
   logic [WIDTH-1:0]   src1_mag, src2_mag;
   logic [WIDTH:0]     mul_sum, div_shift;
   logic [WIDTH-1:0]   div_diff, quo, rem, hi_fix, lo_fix;
   logic               div_ge;
   logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;

   // mult/multu/div/divu share prefix 0110, mf/mt HI/LO share prefix 0100
   assign is_muldiv  = (funct_i[5:2] == 4'b0110);
   assign is_hilo_op = op_valid_i && (is_muldiv || (funct_i[5:2] == 4'b0100));
   assign accept     = (state_q == S_IDLE) && op_valid_i && !flush_i;

   // funct bit 0 clear marks the signed variants
   assign src1_neg = !funct_i[0] && src1_i[WIDTH-1];
   assign src2_neg = !funct_i[0] && src2_i[WIDTH-1];
   assign src1_mag = src1_neg ? -src1_i : src1_i;
   assign src2_mag = src2_neg ? -src2_i : src2_i;

   // One engine step and the final sign fix-up
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, operand_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, operand_q});
      div_diff  = div_shift[WIDTH-1:0] - operand_q;
      div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                         : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      prod_fix  = neg_lo_q ? -acc_q : acc_q;
      quo       = acc_q[WIDTH-1:0];
      rem       = acc_q[2*WIDTH-1:WIDTH];
      // with a zero divisor the remainder path rebuilds the raw dividend
      lo_fix    = dz_q ? '1 : (neg_lo_q ? -quo : quo);
      hi_fix    = neg_rem_q ? -rem : rem;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept && is_muldiv) state_d = funct_i[1] ? S_DIV : S_MUL;
         S_MUL, S_DIV: begin
            if (flush_i)                     state_d = S_IDLE;
            else if (cnt_q == CNT_W'(1))     state_d = S_FIX;
         end
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operand latch, iteration and HI/LO writeback
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         operand_q <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_lo_q  <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         is_div_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (is_muldiv) begin
                     acc_q     <= {{WIDTH{1'b0}}, src1_mag};
                     operand_q <= src2_mag;
                     neg_lo_q  <= src1_neg ^ src2_neg;
                     neg_rem_q <= src1_neg;
                     dz_q      <= (src2_i == '0);
                     is_div_q  <= funct_i[1];
                     cnt_q     <= CNT_W'(WIDTH);
                  end else if (funct_i == F_MTHI) begin
                     hi_q <= src1_i;
                  end else if (funct_i == F_MTLO) begin
                     lo_q <= src1_i;
                  end
               end
            end
            S_MUL, S_DIV: begin
               acc_q <= (state_q == S_DIV) ? div_next : mul_next;
               cnt_q <= flush_i ? '0 : cnt_q - CNT_W'(1);
            end
            S_FIX: begin
               if (is_div_q) begin
                  hi_q <= hi_fix;
                  lo_q <= lo_fix;
               end else begin
                  hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_o  = (state_q != S_IDLE);
   assign done_o  = (state_q == S_FIX);
   assign stall_o = is_hilo_op && busy_o;

   always_comb begin
      hilo_rdata_o = '0;
      if (op_valid_i && (funct_i == F_MFHI))      hilo_rdata_o = hi_q;
      else if (op_valid_i && (funct_i == F_MFLO)) hilo_rdata_o = lo_q;
   end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: directed timing/hazard scenarios plus
// random mult/div traffic compared against plain-arithmetic expected results.
module tb_muldiv_hilo_unit;

   localparam int unsigned W = 32;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         op_valid_i, flush_i;
   logic [5:0]   funct_i;
   logic [W-1:0] src1_i, src2_i;
   logic         stall_o, busy_o, done_o;
   logic [W-1:0] hilo_rdata_o;

   int           vectors = 0;
   int           miscompares = 0;
   logic [31:0]  m_hi, m_lo;

   muldiv_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .op_valid_i   (op_valid_i),
      .funct_i      (funct_i),
      .src1_i       (src1_i),
      .src2_i       (src2_i),
      .flush_i      (flush_i),
      .stall_o      (stall_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .hilo_rdata_o (hilo_rdata_o)
   );

   always #5 clk_i = ~clk_i;

   // Expected {HI, LO} from ordinary integer arithmetic
   function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa, sb;
      logic [63:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = '0;
      case (f)
         F_MULT:  r = sa * sb;
         F_MULTU: r = {32'h0, a} * {32'h0, b};
         F_DIV:   r = (b == 32'h0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
         F_DIVU:  r = (b == 32'h0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
      logic [31:0] h, l;
      op_valid_i = 1'b1;
      funct_i    = F_MFHI;
      #1 h = hilo_rdata_o;
      chk({tag, " rd_stall"}, 64'(stall_o), 64'h0);
      funct_i = F_MFLO;
      #1 l = hilo_rdata_o;
      op_valid_i = 1'b0;
      funct_i    = '0;
      chk({tag, " hi"}, 64'(h), 64'(eh));
      chk({tag, " lo"}, 64'(l), 64'(el));
   endtask

   // Issue one mult/div in cycle 0, check busy/done timing, then HI/LO
   task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string tag);
      op_valid_i = 1'b1;
      funct_i    = f;
      src1_i     = a;
      src2_i     = b;
      step();
      op_valid_i = 1'b0;
      chk({tag, " busy@1"}, 64'(busy_o), 64'h1);
      repeat (W - 1) step();
      chk({tag, " done@W"}, 64'(done_o), 64'h0);
      step();
      chk({tag, " done@W+1"}, 64'({busy_o, done_o}), 64'h3);
      step();
      chk({tag, " idle@W+2"}, 64'({busy_o, done_o}), 64'h0);
      chk_hilo(tag, exp[63:32], exp[31:0]);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
   endtask

   task automatic move_to(input logic [5:0] f, input logic [31:0] v, input string tag);
      op_valid_i = 1'b1;
      funct_i    = f;
      src1_i     = v;
      step();
      op_valid_i = 1'b0;
      chk({tag, " no_busy"}, 64'(busy_o), 64'h0);
      if (f == F_MTHI) m_hi = v;
      else             m_lo = v;
      chk_hilo(tag, m_hi, m_lo);
   endtask

   initial begin
      logic [5:0]  fs [4];
      logic [5:0]  f;
      logic [31:0] a, b;
      logic [63:0] e;
      bit          done_seen;
      fs = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
      op_valid_i = 1'b0; flush_i = 1'b0; funct_i = '0; src1_i = '0; src2_i = '0;
      m_hi = '0; m_lo = '0;

      // Reset values while an mfhi is presented
      #3 op_valid_i = 1'b1; funct_i = F_MFHI;
      #1;
      chk("rst outputs", 64'({stall_o, busy_o, done_o}), 64'h0);
      chk("rst rdata", 64'(hilo_rdata_o), 64'h0);
      op_valid_i = 1'b0;
      step();
      rst_i = 1'b0;
      chk_hilo("rst hilo", 32'h0, 32'h0);

      // Ignored inputs: op_valid low, or a non HI/LO funct
      funct_i = F_MULT; src1_i = 32'h5; src2_i = 32'h3;
      step();
      chk("novalid ignored", 64'(busy_o), 64'h0);
      op_valid_i = 1'b1; funct_i = 6'h20;
      step();
      op_valid_i = 1'b0;
      chk("alu funct ignored", 64'(busy_o), 64'h0);

      // Directed arithmetic cases
      run_op(F_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, "mult -3*7");
      run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu max");
      run_op(F_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "mult -1*-1");
      run_op(F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, "div -7/2");
      run_op(F_DIVU,  32'h0000_0007, 32'h0000_0000, 64'h0000_0007_FFFF_FFFF, "divu 7/0");
      run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div min/-1");
      run_op(F_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFF_FFFB_FFFF_FFFF, "div -5/0");

      // mflo issued at cycle 5 of a mult stalls until the result is visible
      e = ref_op(F_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
      op_valid_i = 1'b1; funct_i = F_MULT; src1_i = 32'h1234_5678; src2_i = 32'h9ABC_DEF0;
      step();
      op_valid_i = 1'b0;
      repeat (4) step();
      op_valid_i = 1'b1; funct_i = F_MFLO;
      #1 chk("mflo stall@5", 64'(stall_o), 64'h1);
      repeat (28) step();
      chk("mflo stall+done@33", 64'({stall_o, done_o}), 64'h3);
      step();
      chk("mflo stall@34", 64'(stall_o), 64'h0);
      chk("mflo data@34", 64'(hilo_rdata_o), 64'(e[31:0]));
      op_valid_i = 1'b0;
      m_hi = e[63:32]; m_lo = e[31:0];

      // Second mult presented while busy waits and starts at cycle 34
      e = ref_op(F_MULT, 32'hFFFF_8000, 32'h0001_2345);
      op_valid_i = 1'b1; funct_i = F_MULTU; src1_i = 32'h0000_0011; src2_i = 32'h0000_0013;
      step();
      op_valid_i = 1'b1; funct_i = 6'h21;
      #1 chk("busy alu funct no stall", 64'(stall_o), 64'h0);
      step();
      step();
      funct_i = F_MULT; src1_i = 32'hFFFF_8000; src2_i = 32'h0001_2345;
      #1 chk("mult2 stall@3", 64'(stall_o), 64'h1);
      repeat (30) step();
      chk("mult2 stall@33", 64'({stall_o, done_o}), 64'h3);
      step();
      chk("mult2 accept@34", 64'({stall_o, busy_o}), 64'h0);
      step();
      op_valid_i = 1'b0;
      chk("mult2 busy@35", 64'(busy_o), 64'h1);
      repeat (31) step();
      chk("mult2 done@66", 64'(done_o), 64'h0);
      step();
      chk("mult2 done@67", 64'(done_o), 64'h1);
      step();
      chk_hilo("mult2 result", e[63:32], e[31:0]);
      m_hi = e[63:32]; m_lo = e[31:0];

      // mtlo, then flush at cycle 10 of a divu
      move_to(F_MTLO, 32'h1234_5678, "mtlo");
      move_to(F_MTHI, 32'hCAFE_0001, "mthi");
      done_seen = 1'b0;
      op_valid_i = 1'b1; funct_i = F_DIVU; src1_i = 32'd100; src2_i = 32'd7;
      step();
      op_valid_i = 1'b0;
      for (int c = 1; c < 10; c++) begin
         done_seen |= done_o;
         step();
      end
      flush_i = 1'b1;
      #1 done_seen |= done_o;
      step();
      flush_i = 1'b0;
      chk("flush busy@11", 64'(busy_o), 64'h0);
      repeat (25) begin
         done_seen |= done_o;
         step();
      end
      chk("flush no done", 64'(done_seen), 64'h0);
      chk_hilo("flush hilo", 32'hCAFE_0001, 32'h1234_5678);

      // Flush during FIX still commits the result
      e = ref_op(F_MULTU, 32'h0000_BEEF, 32'h0000_1001);
      op_valid_i = 1'b1; funct_i = F_MULTU; src1_i = 32'h0000_BEEF; src2_i = 32'h0000_1001;
      step();
      op_valid_i = 1'b0;
      repeat (32) step();
      flush_i = 1'b1;
      #1 chk("fixflush done", 64'(done_o), 64'h1);
      step();
      flush_i = 1'b0;
      chk("fixflush idle", 64'(busy_o), 64'h0);
      chk_hilo("fixflush hilo", e[63:32], e[31:0]);

      // Async reset at cycle 20 of a mult
      op_valid_i = 1'b1; funct_i = F_MULT; src1_i = 32'h7FFF_FFFF; src2_i = 32'h7FFF_FFFF;
      step();
      op_valid_i = 1'b0;
      repeat (19) step();
      op_valid_i = 1'b1; funct_i = F_MFHI;
      #2 rst_i = 1'b1;
      #1;
      chk("midrst outputs", 64'({stall_o, busy_o, done_o}), 64'h0);
      chk("midrst rdata", 64'(hilo_rdata_o), 64'h0);
      op_valid_i = 1'b0;
      step();
      rst_i = 1'b0;
      chk_hilo("midrst hilo", 32'h0, 32'h0);
      run_op(F_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, "post-rst mult");

      // Random traffic against the arithmetic reference
      for (int i = 0; i < 40; i++) begin
         f = fs[$urandom_range(0, 3)];
         a = rnd_val();
         b = rnd_val();
         run_op(f, a, b, ref_op(f, a, b), "rand");
         if ((i % 8) == 7) move_to(($urandom_range(0, 1) == 0) ? F_MTHI : F_MTLO, rnd_val(), "rand mt");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
